// File: rtl/mem_image_loader.sv
// Boot-time image loader: packs a little-endian byte stream into 32-bit words
// and writes them into the instruction or data bank at consecutive addresses.
module mem_image_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             target,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic [7:0]       s_byte,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_data,
  output logic [1:0]       mem_write_select,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [31:0]      checksum
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_FINISH
  } state_t;

  localparam logic [1:0] SEL_NONE = 2'd2;

  state_t           state_q, state_d;
  logic             tgt_q, tgt_d;
  logic [31:0]      base_q, base_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [1:0]       lane_q, lane_d;
  logic [31:0]      tmo_q, tmo_d;
  logic [31:0]      word_q, word_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [1:0]       sel_q, sel_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [31:0]      chk_q, chk_d;
  logic             accept;

  assign accept = s_valid & rdy_q;

  // Next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    tmo_d   = tmo_q;
    word_d  = word_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    chk_d   = chk_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          tgt_d  = target;
          base_d = base_addr;
          cnt_d  = word_count;
          chk_d  = 32'd0;
          err_d  = 1'b0;
          lane_d = 2'd0;
          idx_d  = '0;
          tmo_d  = 32'd0;
          if (word_count == '0) state_d = S_FINISH;
          else                  state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (accept) begin
          word_d[{lane_q, 3'b000} +: 8] = s_byte;
          lane_d = lane_q + 2'd1;
          tmo_d  = 32'd0;
          if (lane_q == 2'd3) begin
            state_d = S_WRITE;
            addr_d  = base_q + 32'(idx_q);
            data_d  = {s_byte, word_q[23:0]};
          end
        end else begin
          tmo_d = tmo_q + 32'd1;
          if (TIMEOUT_CYCLES != 0 && tmo_d == 32'(TIMEOUT_CYCLES)) begin
            err_d   = 1'b1;
            state_d = S_FINISH;
          end
        end
      end
      S_WRITE: begin
        chk_d = chk_q + data_q;
        idx_d = idx_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (idx_d == cnt_q) state_d = S_FINISH;
        else                state_d = S_COLLECT;
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    rdy_d  = (state_d == S_COLLECT);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FINISH);
    sel_d  = (state_d == S_WRITE) ? {1'b0, tgt_d} : SEL_NONE;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tgt_q   <= 1'b0;
      base_q  <= 32'd0;
      cnt_q   <= '0;
      idx_q   <= '0;
      lane_q  <= 2'd0;
      tmo_q   <= 32'd0;
      word_q  <= 32'd0;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      sel_q   <= SEL_NONE;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      chk_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      tmo_q   <= tmo_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      chk_q   <= chk_d;
    end
  end

  assign s_ready          = rdy_q;
  assign mem_addr         = addr_q;
  assign mem_data         = data_q;
  assign mem_write_select = sel_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = err_q;
  assign checksum         = chk_q;

endmodule

// File: tb/tb_mem_image_loader.sv
// Directed bench for mem_image_loader: bank writes, gaps, zero count,
// timeout, address wrap, ignored start and reset during a write.
module tb_mem_image_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        target;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic [7:0]  s_byte;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [1:0]  mem_write_select;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] checksum;

  int checks;
  int failures;
  int nwr;
  int ndone;
  logic [31:0] la [8];
  logic [31:0] ld [8];
  logic [1:0]  ls [8];

  mem_image_loader #(
    .TIMEOUT_CYCLES(8),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .target(target),
    .base_addr(base_addr),
    .word_count(word_count),
    .s_byte(s_byte),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .mem_write_select(mem_write_select),
    .busy(busy),
    .done(done),
    .error(error),
    .checksum(checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory-side observer: logs every write cycle and done pulse
  always @(negedge clk) begin
    if (rst_n && mem_write_select != 2'd2) begin
      if (nwr < 8) begin
        la[nwr] = mem_addr;
        ld[nwr] = mem_data;
        ls[nwr] = mem_write_select;
      end
      nwr = nwr + 1;
    end
    if (rst_n && done) ndone = ndone + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_log();
    nwr   = 0;
    ndone = 0;
  endtask

  task automatic do_start(input logic t, input logic [31:0] b,
                          input logic [15:0] n);
    target     = t;
    base_addr  = b;
    word_count = n;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    s_byte  = b;
    s_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (s_ready) break;
      step();
    end
    if (!s_ready) chk("rdy_timeout", 32'(s_ready), 32'd1);
    step();
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 50; i++) begin
      if (!busy) break;
      step();
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    nwr        = 0;
    ndone      = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    target     = 1'b0;
    base_addr  = 32'd0;
    word_count = 16'd0;
    s_byte     = 8'd0;
    s_valid    = 1'b0;
    repeat (3) step();

    chk("rst_sel", 32'(mem_write_select), 32'd2);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_data", mem_data, 32'd0);
    chk("rst_flags", {27'd0, s_ready, busy, done, error, 1'b0}, 32'd0);
    chk("rst_chk", checksum, 32'd0);
    rst_n = 1'b1;
    step();

    // Two words into the instruction bank
    clr_log();
    do_start(1'b0, 32'h10, 16'd2);
    chk("t1_busy", 32'(busy), 32'd1);
    send_byte(8'h78);
    send_byte(8'h56);
    send_byte(8'h34);
    send_byte(8'h12);
    chk("t1_w0_sel", 32'(mem_write_select), 32'd0);
    send_byte(8'hEF);
    send_byte(8'hBE);
    send_byte(8'hAD);
    send_byte(8'hDE);
    wait_idle("t1_idle");
    chk("t1_nwr", nwr, 32'd2);
    chk("t1_a0", la[0], 32'h10);
    chk("t1_d0", ld[0], 32'h12345678);
    chk("t1_a1", la[1], 32'h11);
    chk("t1_d1", ld[1], 32'hDEADBEEF);
    chk("t1_s1", 32'(ls[1]), 32'd0);
    chk("t1_chk", checksum, 32'hF0E21567);
    chk("t1_done", ndone, 32'd1);
    chk("t1_err", 32'(error), 32'd0);

    // One word into the data bank with gaps between bytes
    clr_log();
    do_start(1'b1, 32'h20, 16'd1);
    send_byte(8'h01);
    repeat (3) step();
    send_byte(8'h02);
    repeat (3) step();
    send_byte(8'h03);
    repeat (3) step();
    send_byte(8'h04);
    wait_idle("t2_idle");
    chk("t2_nwr", nwr, 32'd1);
    chk("t2_sel", 32'(ls[0]), 32'd1);
    chk("t2_addr", la[0], 32'h20);
    chk("t2_data", ld[0], 32'h04030201);
    chk("t2_chk", checksum, 32'h04030201);

    // Zero-count load
    clr_log();
    do_start(1'b0, 32'h5, 16'd0);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_chk", checksum, 32'd0);
    step();
    chk("t3_done_off", 32'(done), 32'd0);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_nwr", nwr, 32'd0);

    // Timeout after five bytes
    clr_log();
    do_start(1'b0, 32'h40, 16'd2);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    repeat (7) step();
    chk("t4_err_early", 32'(error), 32'd0);
    chk("t4_busy_early", 32'(busy), 32'd1);
    step();
    chk("t4_err", 32'(error), 32'd1);
    chk("t4_done", 32'(done), 32'd1);
    step();
    chk("t4_done_off", 32'(done), 32'd0);
    chk("t4_err_sticky", 32'(error), 32'd1);
    chk("t4_nwr", nwr, 32'd1);
    chk("t4_data", ld[0], 32'h44332211);
    chk("t4_chk", checksum, 32'h44332211);

    // Address wrap, and a start pulse while busy
    clr_log();
    do_start(1'b1, 32'hFFFFFFFF, 16'd2);
    chk("t5_err_clr", 32'(error), 32'd0);
    send_byte(8'hA1);
    send_byte(8'hA2);
    send_byte(8'hA3);
    send_byte(8'hA4);
    step();
    target     = 1'b0;
    base_addr  = 32'h100;
    word_count = 16'd1;
    start      = 1'b1;
    step();
    start      = 1'b0;
    send_byte(8'hB1);
    send_byte(8'hB2);
    send_byte(8'hB3);
    send_byte(8'hB4);
    wait_idle("t5_idle");
    chk("t5_nwr", nwr, 32'd2);
    chk("t5_a0", la[0], 32'hFFFFFFFF);
    chk("t5_a1", la[1], 32'h00000000);
    chk("t5_d1", ld[1], 32'hB4B3B2B1);
    chk("t5_s1", 32'(ls[1]), 32'd1);
    chk("t5_chk", checksum, 32'h59575552);
    chk("t5_done", ndone, 32'd1);

    // Reset asserted during the write cycle
    clr_log();
    do_start(1'b0, 32'h80, 16'd1);
    send_byte(8'hC1);
    send_byte(8'hC2);
    send_byte(8'hC3);
    send_byte(8'hC4);
    chk("t6_wr_sel", 32'(mem_write_select), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_sel", 32'(mem_write_select), 32'd2);
    chk("t6_addr", mem_addr, 32'd0);
    chk("t6_data", mem_data, 32'd0);
    chk("t6_flags", {27'd0, s_ready, busy, done, error, 1'b0}, 32'd0);
    chk("t6_chk", checksum, 32'd0);
    step();
    chk("t6_nwr", nwr, 32'd0);
    rst_n = 1'b1;
    step();
    chk("t6_busy_after", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_image_loader.md
Name: mem_image_loader

Overview:
- Write-side initiator for the team's dual-bank instruction/data memory.
- Accepts a little-endian byte stream, for example from a UART receiver, through a valid/ready handshake, and packs every four bytes into a 32-bit word.
- Writes each packed word into the selected bank at consecutive word addresses by driving the memory's addr, data_in and write_select inputs.
- Used at boot to load program and data images, then hands control back to the core.

Parameters:
- TIMEOUT_CYCLES, 65535: idle cycles allowed in COLLECT between accepted bytes before the load aborts. 0 disables the timeout.
- CNT_W, 16: width of word_count and of the internal word index.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle load request. Sampled only in IDLE.
- target  input  1  bank select: 0 = instruction, 1 = data. Latched on start.
- base_addr  input  32  first word address. Latched on start.
- word_count  input  CNT_W  number of words to load. Latched on start.
- s_byte  input  8  stream byte.
- s_valid  input  1  s_byte is valid.
- s_ready  output  1  loader accepts a byte this cycle.
- mem_addr  output  32  to memory addr.
- mem_data  output  32  to memory data_in.
- mem_write_select  output  2  to memory write_select: 0 = instruction, 1 = data, 2 = none.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- error  output  1  timeout abort flag. Sticky until the next accepted start.
- checksum  output  32  wrapping sum of all words written in the current or last load.

Behaviour:
- Reset (asynchronous, rst_n low), state = IDLE:
  - mem_write_select = 2; mem_addr = 0; mem_data = 0.
  - s_ready = 0; busy = 0; done = 0; error = 0; checksum = 0.
  - Byte lane counter = 0; word index = 0; timeout counter = 0.
- States are IDLE, COLLECT, WRITE and FINISH. All outputs are registered.
- IDLE:
  - On start = 1: latch target, base_addr and word_count; clear checksum, error, byte lane counter, word index and timeout counter.
  - If word_count == 0, go to FINISH. Otherwise go to COLLECT.
- COLLECT:
  - s_ready = 1. A byte is accepted when s_valid & s_ready at a rising edge.
  - Lane 0 → bits [7:0], lane 1 → [15:8], lane 2 → [23:16], lane 3 → [31:24].
  - On the 4th accepted byte: the assembled word is complete, and the next state is WRITE with s_ready = 0 during WRITE.
- WRITE (exactly one cycle):
  - mem_write_select = target; mem_addr = base_addr + word index, mod 2^32; mem_data = assembled word. The memory captures the word at the edge that ends this cycle.
  - At that same edge: checksum += word (mod 2^32) and word index += 1.
  - If the new index == word_count, go to FINISH. Otherwise go to COLLECT.
- Outside WRITE:
  - mem_write_select = 2.
  - mem_addr and mem_data hold their last values. This avoids spurious writes because the memory writes on write_select 0 and 1 only.
- FINISH: done = 1 for one cycle, then go to IDLE. busy falls together with done.
- Latency and throughput:
  - From the edge accepting the 4th byte of a word to the memory write edge: 1 cycle.
  - From the final write edge to done = 1: 1 cycle.
  - Peak rate: one word per 5 cycles.
- Timeout:
  - In COLLECT the timeout counter increments on every cycle with no accepted byte, and clears on each accepted byte.
  - When it reaches TIMEOUT_CYCLES (nonzero): error = 1, the partial word is discarded with no write, and the next state is FINISH. done still pulses.
- start while busy is ignored. s_valid outside COLLECT is ignored; no byte is consumed.
- Address wrap: base_addr + index overflows modulo 2^32 with no flag.
- Reset mid-load: all state returns to reset values immediately, and any pending write is dropped. The write_select = 2 reset value ensures no memory write occurs at the next edge.

Test Plan:
- Load 2 words into the instruction bank:
  - Stimulus: start, target = 0, base_addr = 0x10, word_count = 2; bytes 0x78 0x56 0x34 0x12 0xEF 0xBE 0xAD 0xDE with s_valid held high.
  - Response: WRITE cycles drive select = 0, addr 0x10 data 0x12345678, then addr 0x11 data 0xDEADBEEF; checksum = 0xF0E21567; a single done pulse; error = 0.
- Backpressure gaps into the data bank:
  - Stimulus: target = 1, word_count = 1; bytes 0x01 0x02 0x03 0x04 with 3 idle cycles between bytes.
  - Response: one write, select = 1, data 0x04030201; select = 2 on all other cycles.
- Zero-count load:
  - Stimulus: start with word_count = 0.
  - Response: done pulses 1 cycle later; no write cycles; checksum = 0.
- Timeout abort:
  - Stimulus: TIMEOUT_CYCLES = 8; word_count = 2; send 5 bytes, then stall.
  - Response: exactly 1 write; error = 1 and a done pulse after the 8th idle cycle; error clears on the next start.
- Address wrap and ignored start:
  - Stimulus: base_addr = 0xFFFFFFFF, word_count = 2; pulse start again mid-load.
  - Response: writes go to 0xFFFFFFFF then 0x00000000; the second start has no effect.
- Reset mid-load:
  - Stimulus: assert rst_n = 0 during WRITE.
  - Response: select = 2 immediately with no memory update; busy = 0 and all outputs return to reset values.
